// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: memory-side valid/ready bus of the EX/MEM stage
interface ex_mem_stage_if #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
);
  logic                  mem_valid;
  logic                  mem_ready;
  logic [XLEN-1:0]       mem_addr;
  logic [XLEN-1:0]       mem_store_data;
  logic [7:0]            mem_be;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_reg_write;
  logic                  mem_read;
  logic                  mem_write;
  logic                  mem_misaligned;
  modport master (
    output mem_valid, mem_addr, mem_store_data, mem_be, mem_rd,
           mem_reg_write, mem_read, mem_write, mem_misaligned,
    input  mem_ready
  );
  modport slave (
    input  mem_valid, mem_addr, mem_store_data, mem_be, mem_rd,
           mem_reg_write, mem_read, mem_write, mem_misaligned,
    output mem_ready
  );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM register with branch redirect, store decode and 2-entry skid buffer
module ex_mem_stage #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [XLEN-1:0]       ex_alu_result,
  input  logic                  ex_alu_zero,
  input  logic [XLEN-1:0]       ex_rs2_data,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [1:0]            ex_mem_size,
  input  logic                  ex_is_beq,
  input  logic                  ex_is_bne,
  input  logic [XLEN-1:0]       ex_branch_target,
  input  logic                  flush,
  ex_mem_stage_if.master        mem,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_pc,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]       fwd_data
);
  typedef struct packed {
    logic [XLEN-1:0]       addr;
    logic [XLEN-1:0]       data;
    logic [7:0]            be;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  read;
    logic                  write;
    logic                  mis;
  } entry_t;
  entry_t     main_q, skid_q, in_e;
  logic       main_valid, skid_valid, accept, drain, taken, mis;
  logic [7:0] mask;
  assign ex_ready = !skid_valid;
  assign accept   = ex_valid && ex_ready && !flush;
  assign drain    = main_valid && mem.mem_ready;
  assign taken    = (ex_is_beq && ex_alu_zero) || (ex_is_bne && !ex_alu_zero);
  always_comb begin
    mask = ex_mem_size == 2'd0 ? 8'h01 : ex_mem_size == 2'd1 ? 8'h03 :
           ex_mem_size == 2'd2 ? 8'h0f : 8'hff;
    mis  = (ex_mem_read || ex_mem_write) &&
           (ex_mem_size == 2'd1 ? ex_alu_result[0] :
            ex_mem_size == 2'd2 ? |ex_alu_result[1:0] :
            ex_mem_size == 2'd3 ? |ex_alu_result[2:0] : 1'b0);
    in_e = '{
      addr:      ex_alu_result,
      data:      ex_mem_size == 2'd0 ? {8{ex_rs2_data[7:0]}} :
                 ex_mem_size == 2'd1 ? {4{ex_rs2_data[15:0]}} :
                 ex_mem_size == 2'd2 ? {2{ex_rs2_data[31:0]}} : ex_rs2_data,
      be:        mis ? 8'h00 : mask << ex_alu_result[2:0],
      rd:        ex_rd,
      reg_write: ex_reg_write && !(ex_is_beq || ex_is_bne),
      read:      ex_mem_read && !mis,
      write:     ex_mem_write && !mis,
      mis:       mis
    };
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid     <= 1'b0;
      skid_valid     <= 1'b0;
      main_q         <= '0;
      skid_q         <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else if (flush) begin
      main_valid     <= 1'b0;
      skid_valid     <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      redirect_valid <= accept && taken;
      if (accept && taken) redirect_pc <= ex_branch_target;
      if (drain && skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (accept && (!main_valid || drain)) begin
        main_q     <= in_e;
        main_valid <= 1'b1;
      end else if (drain) begin
        main_valid <= 1'b0;
      end
      // accept is impossible while the skid is full, so it never overwrites
      if (accept && main_valid && !mem.mem_ready) begin
        skid_q     <= in_e;
        skid_valid <= 1'b1;
      end
    end
  end
  assign mem.mem_valid      = main_valid;
  assign mem.mem_addr       = main_q.addr;
  assign mem.mem_store_data = main_q.data;
  assign mem.mem_be         = main_q.be;
  assign mem.mem_rd         = main_q.rd;
  assign mem.mem_reg_write  = main_q.reg_write;
  assign mem.mem_read       = main_q.read;
  assign mem.mem_write      = main_q.write;
  assign mem.mem_misaligned = main_q.mis;
  assign fwd_valid = main_valid && main_q.reg_write && |main_q.rd && !main_q.read && !main_q.mis;
  assign fwd_rd    = main_q.rd;
  assign fwd_data  = main_q.addr;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: scoreboard bench for ex_mem_stage with randomized and directed stimulus
module tb_ex_mem_stage;
  logic        clk = 0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_alu_zero, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_is_beq, ex_is_bne, flush;
  logic [63:0] ex_alu_result, ex_rs2_data, ex_branch_target;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_mem_size;
  logic        redirect_valid, fwd_valid;
  logic [63:0] redirect_pc, fwd_data;
  logic [4:0]  fwd_rd;

  ex_mem_stage_if #(.XLEN(64), .REG_ADDR_W(5)) bus ();

  ex_mem_stage #(.XLEN(64), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_alu_zero(ex_alu_zero), .ex_rs2_data(ex_rs2_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size), .ex_is_beq(ex_is_beq),
    .ex_is_bne(ex_is_bne), .ex_branch_target(ex_branch_target), .flush(flush),
    .mem(bus.master), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, zero, rw, rd_op, wr_op, beq, bne, flush, mready;
    logic [63:0] addr, rs2, target;
    logic [4:0]  rd;
    logic [1:0]  size;
  } stim_t;

  typedef struct {
    logic [63:0] addr, data;
    logic [7:0]  be;
    logic [4:0]  rd;
    logic        rw, rd_en, wr_en, mis;
  } ent_t;

  ent_t        q[$];
  int          checks = 0, errors = 0;
  bit          run = 0;
  logic        exp_redir = 0;
  logic [63:0] exp_pc = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected memory-side entry derived byte-by-byte from the access size
  function automatic ent_t model(stim_t s);
    ent_t e;
    int   n   = 1 << s.size;
    int   off = int'(s.addr[2:0]);
    e.addr  = s.addr;
    e.rd    = s.rd;
    e.mis   = (s.rd_op || s.wr_op) && (s.addr % 64'(n) != 0);
    e.rw    = s.rw && !s.beq && !s.bne;
    e.rd_en = s.rd_op && !e.mis;
    e.wr_en = s.wr_op && !e.mis;
    for (int i = 0; i < 8; i++) begin
      e.be[i]         = !e.mis && i >= off && i < off + n;
      e.data[8*i +: 8] = s.rs2[8*(i % n) +: 8];
    end
    return e;
  endfunction

  function automatic stim_t base();
    stim_t s;
    s = '{valid: 1'b1, zero: 1'b0, rw: 1'b0, rd_op: 1'b0, wr_op: 1'b0, beq: 1'b0, bne: 1'b0,
          flush: 1'b0, mready: 1'b1, addr: 64'h0, rs2: 64'h0, target: 64'h0, rd: 5'd0, size: 2'd3};
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s = base();
    int    k = $urandom_range(0, 5);
    s.valid  = $urandom_range(0, 3) != 0;
    s.zero   = 1'($urandom);
    s.addr   = {32'($urandom), 32'($urandom)};
    s.rs2    = {32'($urandom), 32'($urandom)};
    s.target = {32'($urandom), 32'($urandom)};
    s.rd     = 5'($urandom);
    s.size   = 2'($urandom);
    s.rd_op  = k == 0;
    s.wr_op  = k == 1;
    s.beq    = k == 2;
    s.bne    = k == 3;
    s.rw     = k != 1 && 1'($urandom);
    s.flush  = $urandom_range(0, 24) == 0;
    s.mready = $urandom_range(0, 2) != 0;
    return s;
  endfunction

  // Called just after a rising edge; returns just after the next one
  task automatic step(stim_t s);
    logic acc;
    ex_valid = s.valid; ex_alu_result = s.addr; ex_alu_zero = s.zero; ex_rs2_data = s.rs2;
    ex_rd = s.rd; ex_reg_write = s.rw; ex_mem_read = s.rd_op; ex_mem_write = s.wr_op;
    ex_mem_size = s.size; ex_is_beq = s.beq; ex_is_bne = s.bne; ex_branch_target = s.target;
    flush = s.flush; bus.mem_ready = s.mready;
    acc = s.valid && ex_ready && !s.flush;
    @(posedge clk);
    if (s.flush) q.delete();
    if (acc) q.push_back(model(s));
    exp_redir = acc && ((s.beq && s.zero) || (s.bne && !s.zero));
    if (exp_redir) exp_pc = s.target;
    #1;
  endtask

  // Monitor: entry occupancy dictates ex_ready/mem_valid; head of queue is the presented entry
  initial begin
    ent_t e;
    logic fv;
    forever begin
      @(negedge clk);
      if (run) begin
        chk("ex_ready", 64'(ex_ready), 64'(q.size() < 2));
        chk("mem_valid", 64'(bus.mem_valid), 64'(q.size() != 0));
        chk("redirect_valid", 64'(redirect_valid), 64'(exp_redir));
        if (exp_redir) chk("redirect_pc", redirect_pc, exp_pc);
        if (q.size() != 0) begin
          e  = q[0];
          fv = e.rw && e.rd != 0 && !e.rd_en && !e.mis;
          chk("mem_addr", bus.mem_addr, e.addr);
          chk("mem_store_data", bus.mem_store_data, e.data);
          chk("mem_be", 64'(bus.mem_be), 64'(e.be));
          chk("mem_rd", 64'(bus.mem_rd), 64'(e.rd));
          chk("mem_reg_write", 64'(bus.mem_reg_write), 64'(e.rw));
          chk("mem_read", 64'(bus.mem_read), 64'(e.rd_en));
          chk("mem_write", 64'(bus.mem_write), 64'(e.wr_en));
          chk("mem_misaligned", 64'(bus.mem_misaligned), 64'(e.mis));
          chk("fwd_valid", 64'(fwd_valid), 64'(fv));
          if (fv) begin
            chk("fwd_rd", 64'(fwd_rd), 64'(e.rd));
            chk("fwd_data", fwd_data, e.addr);
          end
          if (bus.mem_ready) void'(q.pop_front());
        end else
          chk("fwd_valid_idle", 64'(fwd_valid), 64'd0);
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1;
    s = base();
    s.valid = 0;
    s.mready = 0;
    ex_valid = 0; ex_alu_result = 0; ex_alu_zero = 0; ex_rs2_data = 0; ex_rd = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_size = 0; ex_is_beq = 0;
    ex_is_bne = 0; ex_branch_target = 0; flush = 0; bus.mem_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("rst_ex_ready", 64'(ex_ready), 64'd1);
    chk("rst_redirect", 64'(redirect_valid), 64'd0);
    chk("rst_mem_addr", bus.mem_addr, 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    @(posedge clk);
    #1 run = 1;
    // back-to-back stream
    for (int i = 1; i <= 4; i++) begin
      s = base(); s.addr = 64'(i * 16); s.rw = 1; s.rd = 5'(i); step(s);
    end
    // backpressure in the middle of a stream
    for (int i = 0; i < 7; i++) begin
      s = base(); s.addr = 64'h100 + 64'(i * 8); s.rw = 1; s.rd = 5'(i + 3);
      s.mready = !(i >= 1 && i <= 3);
      step(s);
    end
    // SH at offset 6, then misaligned SW
    s = base(); s.wr_op = 1; s.size = 1; s.addr = 64'h1000_0006; s.rs2 = 64'h1234; step(s);
    s.size = 2; step(s);
    s = base(); s.rd_op = 1; s.size = 0; s.addr = 64'h1000_0007; s.rs2 = 64'h5a; step(s);
    // BEQ taken, BNE not taken
    s = base(); s.beq = 1; s.zero = 1; s.rw = 1; s.rd = 1; s.target = 64'h8000_0040; step(s);
    s = base(); s.bne = 1; s.zero = 1; s.target = 64'h8000_0080; step(s);
    s = base(); s.valid = 0; step(s);
    // fill main and skid, then flush with a new input present
    for (int i = 0; i < 3; i++) begin
      s = base(); s.mready = 0; s.addr = 64'h200 + 64'(i); s.rw = 1; s.rd = 7; step(s);
    end
    s = base(); s.mready = 0; s.flush = 1; s.beq = 1; s.zero = 1; s.target = 64'h44; step(s);
    // forwarding candidates
    s = base(); s.rw = 1; s.rd = 5; s.addr = 64'h99; step(s);
    s.rd = 0; step(s);
    s.rd = 5; s.rd_op = 1; s.addr = 64'h98; step(s);
    for (int i = 0; i < 400; i++) step(rnd());
    s = base(); s.valid = 0;
    for (int i = 0; i < 20 && q.size() != 0; i++) step(s);
    chk("drain_empty", 64'(q.size()), 64'd0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
